// File: rtl/sd_mem_arbiter.sv
// Two-port arbiter sequencing single-byte ops onto a 1-cycle-latency synchronous buffer memory.
// Fixed 3-cycle request-to-ack, one op per 4 cycles; `SD_MEM_ARB_RR_EN selects round-robin over port-0 priority.
module sd_mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req0,
   input  logic              i_wr_nrd0,
   input  logic [ADDR_W-1:0] i_addr0,
   input  logic [DATA_W-1:0] i_wdata0,
   input  logic              i_req1,
   input  logic              i_wr_nrd1,
   input  logic [ADDR_W-1:0] i_addr1,
   input  logic [DATA_W-1:0] i_wdata1,
   output logic              o_ack0,
   output logic              o_ack1,
   output logic [DATA_W-1:0] o_rdata0,
   output logic [DATA_W-1:0] o_rdata1,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   output logic              o_mem_write,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic              o_busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_ACK   = 2'd3
   } state_t;

   state_t            state_q, state_d;

   logic              gnt_vld;
   logic              gnt_id;
   logic              gnt_wr;
   logic [ADDR_W-1:0] gnt_addr;
   logic [DATA_W-1:0] gnt_wdata;

   logic              id_q, id_d;
   logic              wr_q, wr_d;
   logic              ack0_q, ack0_d;
   logic              ack1_q, ack1_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              mem_write_q, mem_write_d;
   logic              busy_q, busy_d;

   assign gnt_vld = i_req0 | i_req1;

`ifdef SD_MEM_ARB_RR_EN
   logic last_q, last_d;

   // Tie goes to the port not granted last; a lone requester always wins.
   assign gnt_id = i_req1 & (~i_req0 | ~last_q);
   assign last_d = ((state_q == ST_IDLE) && gnt_vld) ? gnt_id : last_q;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end
`else
   assign gnt_id = ~i_req0;
`endif

   assign gnt_wr    = gnt_id ? i_wr_nrd1 : i_wr_nrd0;
   assign gnt_addr  = gnt_id ? i_addr1   : i_addr0;
   assign gnt_wdata = gnt_id ? i_wdata1  : i_wdata0;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (gnt_vld) state_d = ST_ISSUE;
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT:  state_d = ST_ACK;
         ST_ACK:   state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Address and write data hold their last value; only mem_write qualifies a write.
   always_comb begin
      id_d        = id_q;
      wr_d        = wr_q;
      ack0_d      = 1'b0;
      ack1_d      = 1'b0;
      rdata0_d    = rdata0_q;
      rdata1_d    = rdata1_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_write_d = 1'b0;
      busy_d      = (state_d != ST_IDLE);
      case (state_q)
         ST_IDLE: begin
            if (gnt_vld) begin
               id_d        = gnt_id;
               wr_d        = gnt_wr;
               mem_addr_d  = gnt_addr;
               mem_wdata_d = gnt_wdata;
               mem_write_d = gnt_wr;
            end
         end
         ST_WAIT: begin
            if (!wr_q) begin
               if (id_q) begin
                  rdata1_d = i_mem_rdata;
               end else begin
                  rdata0_d = i_mem_rdata;
               end
            end
            ack0_d = ~id_q;
            ack1_d = id_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         id_q        <= 1'b0;
         wr_q        <= 1'b0;
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_write_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         id_q        <= id_d;
         wr_q        <= wr_d;
         ack0_q      <= ack0_d;
         ack1_q      <= ack1_d;
         rdata0_q    <= rdata0_d;
         rdata1_q    <= rdata1_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_write_q <= mem_write_d;
         busy_q      <= busy_d;
      end
   end

   assign o_ack0      = ack0_q;
   assign o_ack1      = ack1_q;
   assign o_rdata0    = rdata0_q;
   assign o_rdata1    = rdata1_q;
   assign o_mem_addr  = mem_addr_q;
   assign o_mem_wdata = mem_wdata_q;
   assign o_mem_write = mem_write_q;
   assign o_busy      = busy_q;

endmodule

// File: tb/tb_sd_mem_arbiter.sv
// Directed bench for sd_mem_arbiter with a behavioural 1-cycle-latency memory.
`timescale 1ns/1ps
module tb_sd_mem_arbiter;
   localparam int AW = 32;
   localparam int DW = 8;

   logic          clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          req0, req1, wr0, wr1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wd0, wd1;
   logic          ack0, ack1;
   logic [DW-1:0] rd0, rd1;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_write;
   logic [DW-1:0] mem_rdata;
   logic          busy;

   int n_tests = 0;
   int n_fail  = 0;

   sd_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req0(req0), .i_wr_nrd0(wr0), .i_addr0(addr0), .i_wdata0(wd0),
      .i_req1(req1), .i_wr_nrd1(wr1), .i_addr1(addr1), .i_wdata1(wd1),
      .o_ack0(ack0), .o_ack1(ack1), .o_rdata0(rd0), .o_rdata1(rd1),
      .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_write(mem_write),
      .i_mem_rdata(mem_rdata), .o_busy(busy)
   );

   logic [7:0] mem [256];
   always @(posedge clk) begin
      if (mem_write === 1'b1) mem[mem_addr[7:0]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[7:0]];
   end

   typedef struct {
      logic          req0, req1, wr0, wr1;
      logic [AW-1:0] a0, a1;
      logic [DW-1:0] d0, d1;
      logic          exp_port;
      logic [DW-1:0] exp_rd0, exp_rd1;
   } vec_t;

   function automatic vec_t mk(input logic r0, input logic r1, input logic w0, input logic w1,
                               input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                               input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                               input logic ep, input logic [DW-1:0] e0, input logic [DW-1:0] e1);
      vec_t v;
      v.req0 = r0; v.req1 = r1; v.wr0 = w0; v.wr1 = w1;
      v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
      v.exp_port = ep; v.exp_rd0 = e0; v.exp_rd1 = e1;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Ticks until an ack appears (bounded); lat stays -1 if none arrives.
   task automatic wait_ack(output int lat, output logic got0, output logic got1,
                           output int wr_cnt, output logic [AW-1:0] iss_addr,
                           output logic [DW-1:0] iss_wdata);
      lat = -1; got0 = 1'b0; got1 = 1'b0; wr_cnt = 0; iss_addr = '0; iss_wdata = '0;
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (mem_write) wr_cnt++;
         if (c == 1) begin
            iss_addr  = mem_addr;
            iss_wdata = mem_wdata;
         end
         if (ack0 || ack1) begin
            lat  = c;
            got0 = ack0;
            got1 = ack1;
            break;
         end
      end
   endtask

   vec_t          vec [8];
   int            lat, wr_cnt, n_ack, both;
   logic          g0, g1, seen, win_wr, e;
   logic [AW-1:0] ia;
   logic [DW-1:0] iw;
   int            ack_cyc [8];
   logic          ack_port [8];

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h20] = 8'h3C;

      vec[0] = mk(1, 0, 1, 0, 32'h0000_0010, 32'h0,          8'hA5, 8'h00, 0, 8'h3C, 8'h00);
      vec[1] = mk(1, 0, 0, 0, 32'h0000_0010, 32'h0,          8'h00, 8'h00, 0, 8'hA5, 8'h00);
      vec[2] = mk(0, 1, 0, 1, 32'h0,          32'hDEAD_BE55, 8'h00, 8'h5A, 1, 8'hA5, 8'h00);
      vec[3] = mk(0, 1, 0, 0, 32'h0,          32'hDEAD_BE55, 8'h00, 8'h00, 1, 8'hA5, 8'h5A);
      vec[4] = mk(1, 1, 0, 1, 32'h0000_0055, 32'h0000_0020, 8'h00, 8'h77, 0, 8'h5A, 8'h5A);
      vec[5] = mk(0, 1, 0, 0, 32'h0,          32'h0000_0010, 8'h00, 8'h00, 1, 8'h5A, 8'hA5);
      vec[6] = mk(1, 0, 1, 0, 32'hFFFF_FFF0, 32'h0,          8'hC3, 8'h00, 0, 8'h5A, 8'hA5);
      vec[7] = mk(1, 0, 0, 0, 32'hFFFF_FFF0, 32'h0,          8'h00, 8'h00, 0, 8'hC3, 8'hA5);

      // Reset held with a pending read on port 0.
      rst_n = 1'b0; req0 = 1'b1; wr0 = 1'b0; addr0 = 32'h20; wd0 = '0;
      req1 = 1'b0; wr1 = 1'b0; addr1 = '0; wd1 = '0;
      seen = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         seen = seen | ack0 | ack1;
      end
      check("reset no ack", {63'd0, seen}, 64'd0);
      check("reset rdata0", {56'd0, rd0}, 64'd0);
      check("reset rdata1", {56'd0, rd1}, 64'd0);
      check("reset mem_addr", {32'd0, mem_addr}, 64'd0);
      check("reset mem_wdata", {56'd0, mem_wdata}, 64'd0);
      check("reset mem_write", {63'd0, mem_write}, 64'd0);
      check("reset busy", {63'd0, busy}, 64'd0);
      rst_n = 1'b1;
      wait_ack(lat, g0, g1, wr_cnt, ia, iw);
      check("post-reset latency", 64'(lat), 64'd3);
      check("post-reset ack0", {63'd0, g0}, 64'd1);
      check("post-reset rdata0", {56'd0, rd0}, 64'h3C);
      req0 = 1'b0;
      tick();

      for (int i = 0; i < 8; i++) begin
         req0 = vec[i].req0; req1 = vec[i].req1; wr0 = vec[i].wr0; wr1 = vec[i].wr1;
         addr0 = vec[i].a0; addr1 = vec[i].a1; wd0 = vec[i].d0; wd1 = vec[i].d1;
         win_wr = vec[i].exp_port ? vec[i].wr1 : vec[i].wr0;
         wait_ack(lat, g0, g1, wr_cnt, ia, iw);
         check($sformatf("v%0d latency", i), 64'(lat), 64'd3);
         check($sformatf("v%0d ack0", i), {63'd0, g0}, {63'd0, ~vec[i].exp_port});
         check($sformatf("v%0d ack1", i), {63'd0, g1}, {63'd0, vec[i].exp_port});
         check($sformatf("v%0d issue addr", i), {32'd0, ia},
               {32'd0, vec[i].exp_port ? vec[i].a1 : vec[i].a0});
         check($sformatf("v%0d write pulses", i), 64'(wr_cnt), {63'd0, win_wr});
         if (win_wr)
            check($sformatf("v%0d issue wdata", i), {56'd0, iw},
                  {56'd0, vec[i].exp_port ? vec[i].d1 : vec[i].d0});
         check($sformatf("v%0d rdata0", i), {56'd0, rd0}, {56'd0, vec[i].exp_rd0});
         check($sformatf("v%0d rdata1", i), {56'd0, rd1}, {56'd0, vec[i].exp_rd1});
         req0 = 1'b0; req1 = 1'b0;
         tick();
         check($sformatf("v%0d ack one cycle", i), {63'd0, ack0 | ack1}, 64'd0);
         check($sformatf("v%0d idle busy", i), {63'd0, busy}, 64'd0);
      end

      // Both ports held continuously for 20 cycles from a fresh reset.
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      req0 = 1'b1; wr0 = 1'b0; addr0 = 32'h10;
      req1 = 1'b1; wr1 = 1'b0; addr1 = 32'h20;
      n_ack = 0; both = 0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (ack0 && ack1) both++;
         if (ack0 || ack1) begin
            if (n_ack < 8) begin
               ack_cyc[n_ack]  = c;
               ack_port[n_ack] = ack1;
            end
            n_ack++;
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      check("tie ack count", 64'(n_ack), 64'd5);
      check("tie dual ack", 64'(both), 64'd0);
      for (int k = 0; k < 5 && k < n_ack; k++) begin
`ifdef SD_MEM_ARB_RR_EN
         e = (k % 2 == 1);
`else
         e = 1'b0;
`endif
         check($sformatf("tie ack%0d cycle", k), 64'(ack_cyc[k]), 64'(3 + 4 * k));
         check($sformatf("tie ack%0d port", k), {63'd0, ack_port[k]}, {63'd0, e});
      end
      check("tie rdata0", {56'd0, rd0}, 64'hA5);
      tick();

      // Reset lands during WAIT of a port 1 read.
      req1 = 1'b1; wr1 = 1'b0; addr1 = 32'h20;
      tick(); tick();
      check("midop busy in wait", {63'd0, busy}, 64'd1);
      rst_n = 1'b0;
      tick();
      check("midop no ack1", {63'd0, ack1}, 64'd0);
      check("midop busy", {63'd0, busy}, 64'd0);
      check("midop mem_write", {63'd0, mem_write}, 64'd0);
      check("midop rdata1", {56'd0, rd1}, 64'd0);
      rst_n = 1'b1;
      wait_ack(lat, g0, g1, wr_cnt, ia, iw);
      check("midop retry latency", 64'(lat), 64'd3);
      check("midop retry ack1", {63'd0, g1}, 64'd1);
      check("midop retry rdata1", {56'd0, rd1}, 64'h3C);
      req1 = 1'b0;
      tick();

      // Port 1 holds its request across the ack with a new address.
      req1 = 1'b1; wr1 = 1'b0; addr1 = 32'h10;
      wait_ack(lat, g0, g1, wr_cnt, ia, iw);
      check("b2b first latency", 64'(lat), 64'd3);
      check("b2b first rdata1", {56'd0, rd1}, 64'hA5);
      addr1 = 32'h20;
      tick();
      check("b2b idle gap busy", {63'd0, busy}, 64'd0);
      wait_ack(lat, g0, g1, wr_cnt, ia, iw);
      check("b2b second latency", 64'(lat), 64'd3);
      check("b2b second addr", {32'd0, ia}, 64'h20);
      check("b2b second ack1", {63'd0, g1}, 64'd1);
      check("b2b second rdata1", {56'd0, rd1}, 64'h3C);
      check("b2b rdata0 untouched", {56'd0, rd0}, 64'd0);
      req1 = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
